// File: rtl/decoder_scan_seq.sv
// Scan sequencer driving the A input of a 3-to-8 decoder: IDLE/RUN/DONE, prescaled stepping, single or continuous pass.
// Optional: define SCAN_MASK_EN to skip indices whose latched mask bit is 0 (otherwise mask is ignored).
module decoder_scan_seq #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       single,
  input  logic       dir,
  input  logic [7:0] mask,
  output logic [2:0] A,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam int PW = ($clog2(PRESCALE + 1) < 1) ? 1 : $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] LAST_CNT = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] cnt;
  logic          dir_q;
  logic          single_q;
  logic [7:0]    start_mask;
  logic [7:0]    run_mask;

`ifdef SCAN_MASK_EN
  logic [7:0] mask_q;
  assign start_mask = mask;
  assign run_mask   = mask_q;
`else
  // Every index is enabled; the mask port is kept for interface compatibility only.
  logic unused_mask;
  assign unused_mask = ^mask;
  assign start_mask  = 8'hFF;
  assign run_mask    = 8'hFF;
`endif

  // First enabled index in the scan direction (lowest when ascending, highest when descending).
  function automatic logic [2:0] first_idx(input logic [7:0] m, input logic d);
    logic [2:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[d ? i : 7 - i]) f = 3'(d ? i : 7 - i);
    end
    return f;
  endfunction

  // Nearest enabled index after cur in direction d, wrapping modulo 8.
  function automatic logic [2:0] next_idx(input logic [2:0] cur, input logic [7:0] m, input logic d);
    logic [2:0] n;
    logic [2:0] c;
    n = cur;
    for (int k = 7; k >= 1; k--) begin
      c = d ? cur - 3'(k) : cur + 3'(k);
      if (m[c]) n = c;
    end
    return n;
  endfunction

  logic       tick;
  logic       at_last;
  logic [2:0] nxt;

  assign tick    = (cnt == LAST_CNT);
  assign at_last = (A == first_idx(run_mask, !dir_q));
  assign nxt     = next_idx(A, run_mask, dir_q);

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      A        <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      dir_q    <= 1'b0;
      single_q <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && (|start_mask)) begin
            state    <= RUN;
            dir_q    <= dir;
            single_q <= single;
`ifdef SCAN_MASK_EN
            mask_q   <= mask;
`endif
            A        <= first_idx(start_mask, dir);
            valid    <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (tick) begin
            cnt <= '0;
            if (at_last && single_q) begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end else begin
              A <= nxt;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: three instances (PRESCALE 4, 2, 1) with directed scans.
// Expected index/done events are queued per instance and consumed by a negedge monitor.
module tb_decoder_scan_seq;

  localparam int NDUT = 3;

  typedef struct packed {
    logic       is_done;
    logic [2:0] a;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i  [NDUT];
  logic       stop_i   [NDUT];
  logic       single_i [NDUT];
  logic       dir_i    [NDUT];
  logic [7:0] mask_i   [NDUT];
  logic [2:0] a_o      [NDUT];
  logic       valid_o  [NDUT];
  logic       busy_o   [NDUT];
  logic       done_o   [NDUT];

  exp_t sb [NDUT][$];
  int   n_checks = 0;
  int   n_fail   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    decoder_scan_seq #(.PRESCALE(g == 0 ? 4 : (g == 1 ? 2 : 1))) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start_i[g]),
      .stop   (stop_i[g]),
      .single (single_i[g]),
      .dir    (dir_i[g]),
      .mask   (mask_i[g]),
      .A      (a_o[g]),
      .valid  (valid_o[g]),
      .busy   (busy_o[g]),
      .done   (done_o[g])
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every cycle an instance shows valid or done, one queued event must match.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int d = 0; d < NDUT; d++) begin
        if (valid_o[d] || done_o[d]) begin
          if (sb[d].size() == 0) begin
            check($sformatf("dut%0d unexpected output {done,valid,A}", d),
                  32'({done_o[d], valid_o[d], a_o[d]}), 32'h0);
          end else begin
            e = sb[d].pop_front();
            check($sformatf("dut%0d scan event {done,valid,A}", d),
                  32'({done_o[d], valid_o[d], a_o[d]}),
                  32'({e.is_done, !e.is_done, e.a}));
          end
        end
      end
    end
  end

  task automatic push_scan(input int d, input logic [2:0] idx, input int reps);
    for (int r = 0; r < reps; r++) sb[d].push_back({1'b0, idx});
  endtask

  task automatic push_done(input int d, input logic [2:0] idx);
    sb[d].push_back({1'b1, idx});
  endtask

  // Returns at the negedge of the first cycle after the start edge.
  task automatic do_start(input int d, input logic dr, input logic sg, input logic [7:0] m);
    @(negedge clk);
    dir_i[d]    = dr;
    single_i[d] = sg;
    mask_i[d]   = m;
    start_i[d]  = 1'b1;
    @(negedge clk);
    start_i[d]  = 1'b0;
  endtask

  // Counts cycles after the start edge until done is seen (bounded).
  task automatic wait_done(input int d, input int cyc0, input int exp_cyc, input string name);
    int cyc;
    cyc = cyc0;
    while (done_o[d] !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      start_i[d] = 1'b0; stop_i[d] = 1'b0; single_i[d] = 1'b0;
      dir_i[d] = 1'b0; mask_i[d] = 8'h00;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("dut%0d reset A", d), 32'(a_o[d]), 32'h0);
      check($sformatf("dut%0d reset valid", d), 32'(valid_o[d]), 32'h0);
      check($sformatf("dut%0d reset busy", d), 32'(busy_o[d]), 32'h0);
      check($sformatf("dut%0d reset done", d), 32'(done_o[d]), 32'h0);
    end
    rst = 1'b0;

    // PRESCALE=4 ascending single pass; mid-run start pulse and control changes must not matter.
    for (int i = 0; i < 8; i++) push_scan(0, 3'(i), 4);
    push_done(0, 3'd7);
    do_start(0, 1'b0, 1'b1, 8'hFF);
    dir_i[0] = 1'b1; single_i[0] = 1'b0; mask_i[0] = 8'h00;
    repeat (5) @(negedge clk);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    wait_done(0, 7, 33, "p4 asc single done cycle");
    check("p4 busy during done", 32'(busy_o[0]), 32'h1);
    @(negedge clk);
    check("p4 busy after done", 32'(busy_o[0]), 32'h0);
    check("p4 A holds last", 32'(a_o[0]), 32'h7);
    check("p4 done one cycle", 32'(done_o[0]), 32'h0);

    // start and stop together in IDLE: stop wins.
    @(negedge clk);
    dir_i[0] = 1'b0; single_i[0] = 1'b1; mask_i[0] = 8'hFF;
    start_i[0] = 1'b1; stop_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0; stop_i[0] = 1'b0;
    check("start+stop valid", 32'(valid_o[0]), 32'h0);
    check("start+stop busy", 32'(busy_o[0]), 32'h0);

    // PRESCALE=2 descending continuous, stop on the tick edge while A=6 (second pass).
    for (int i = 7; i >= 0; i--) push_scan(1, 3'(i), 2);
    push_scan(1, 3'd7, 2);
    push_scan(1, 3'd6, 2);
    do_start(1, 1'b1, 1'b0, 8'hFF);
    repeat (19) @(negedge clk);
    check("p2 A before stop", 32'(a_o[1]), 32'h6);
    stop_i[1] = 1'b1;
    @(negedge clk);
    stop_i[1] = 1'b0;
    check("p2 stop valid", 32'(valid_o[1]), 32'h0);
    check("p2 stop A holds", 32'(a_o[1]), 32'h6);
    check("p2 stop no done", 32'(done_o[1]), 32'h0);
    check("p2 stop busy", 32'(busy_o[1]), 32'h0);

    // Asynchronous reset mid-run while A=5.
    for (int i = 0; i < 5; i++) push_scan(0, 3'(i), 4);
    push_scan(0, 3'd5, 2);
    do_start(0, 1'b0, 1'b0, 8'hFF);
    repeat (21) @(negedge clk);
    check("p4 A before reset", 32'(a_o[0]), 32'h5);
    #2 rst = 1'b1;
    #1;
    check("async rst A", 32'(a_o[0]), 32'h0);
    check("async rst valid", 32'(valid_o[0]), 32'h0);
    check("async rst busy", 32'(busy_o[0]), 32'h0);
    check("async rst done", 32'(done_o[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post rst stays idle", 32'({busy_o[0], valid_o[0], done_o[0]}), 32'h0);

    // PRESCALE=1 ascending single: one index per cycle, done on the 9th cycle.
    for (int i = 0; i < 8; i++) push_scan(2, 3'(i), 1);
    push_done(2, 3'd7);
`ifdef SCAN_MASK_EN
    do_start(2, 1'b0, 1'b1, 8'hFF);
`else
    do_start(2, 1'b0, 1'b1, 8'h00);
`endif
    wait_done(2, 1, 9, "p1 asc single done cycle");
    @(negedge clk);
    check("p1 busy after done", 32'(busy_o[2]), 32'h0);

    // PRESCALE=1 descending single: ends at index 0.
    for (int i = 7; i >= 0; i--) push_scan(2, 3'(i), 1);
    push_done(2, 3'd0);
    do_start(2, 1'b1, 1'b1, 8'hFF);
    wait_done(2, 1, 9, "p1 desc single done cycle");
    @(negedge clk);
    check("p1 desc A holds last", 32'(a_o[2]), 32'h0);

`ifdef SCAN_MASK_EN
    // Masked scan visits only enabled indices; an empty mask is ignored.
    push_scan(2, 3'd2, 1);
    push_scan(2, 3'd5, 1);
    push_scan(2, 3'd7, 1);
    push_done(2, 3'd7);
    do_start(2, 1'b0, 1'b1, 8'b1010_0100);
    wait_done(2, 1, 4, "mask scan done cycle");
    do_start(2, 1'b0, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    check("empty mask ignored", 32'({busy_o[2], valid_o[2], done_o[2]}), 32'h0);
`endif

    @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("dut%0d events left in scoreboard", d), 32'(sb[d].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, clock cycles each index is held (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a scan, sampled in IDLE only.
REQ-005 SHALL have port stop  input  1  abort request, sampled in RUN and IDLE.
REQ-006 SHALL have port single  input  1  1 = one pass then finish, 0 = continuous wrap; latched at start.
REQ-007 SHALL have port dir  input  1  0 = ascending, 1 = descending; latched at start.
REQ-008 SHALL have port mask  input  8  per-index enable, used only when SCAN_MASK_EN is defined; latched at start.
REQ-009 SHALL have port A  output  3  registered index driving the 3-to-8 decoder A input.
REQ-010 SHALL have port valid  output  1  high while A is a live scan index.
REQ-011 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of a single pass.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 and stop=0 -> RUN next edge; A loads first index (0 if dir=0, 7 if dir=1); valid=1; prescaler cleared to 0.
REQ-015 IDLE: start and stop both 1 -> remain IDLE (stop wins).
REQ-016 RUN: prescaler counts 0..PRESCALE-1; tick when count = PRESCALE-1, then count returns to 0; each index held exactly PRESCALE cycles.
REQ-017 RUN on tick, not last index: A advances +1 (dir=0) or -1 (dir=1).
REQ-018 RUN on tick, continuous mode: wrap 7->0 ascending, 0->7 descending; no gap cycle, valid stays 1.
REQ-019 RUN on tick, single mode, at last index (7 ascending / 0 descending): -> DONE; valid=0; A holds last index.
REQ-020 DONE: done=1 for exactly one cycle, busy=1, then -> IDLE unconditionally; start ignored in DONE.
REQ-021 RUN: stop=1 -> IDLE next edge; valid=0; done not asserted; A holds current index; stop takes priority over tick.
REQ-022 start asserted in RUN or DONE SHALL be ignored; dir/single/mask changes during RUN SHALL have no effect.
REQ-023 PRESCALE=1 SHALL step A every cycle; first index held one cycle.
REQ-024 Prescaler width SHALL be $clog2(PRESCALE+1) bits, minimum 1.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) force state=IDLE, A=0, valid=0, busy=0, done=0, prescaler=0, latched dir/single/mask=0.
REQ-026 rst asserted mid-RUN SHALL abort the scan with no done pulse; after release, block waits for new start.

Configuration
REQ-027 Macro SCAN_MASK_EN: when defined, indices with latched mask bit 0 SHALL be skipped; start loads first enabled index in scan direction; advance goes to next enabled index (wrapping in continuous mode); single pass ends after last enabled index in direction; start with mask=8'h00 SHALL be ignored (stay IDLE).
REQ-028 Without SCAN_MASK_EN: mask port SHALL be present but ignored; all 8 indices scanned.

Verification
REQ-029 PRESCALE=4, start with dir=0 single=1 -> A=0..7 each 4 cycles, valid high 32 cycles, then done=1 one cycle, busy low next cycle, A=7.
REQ-030 PRESCALE=2, dir=1 single=0 -> A=7,6,...,0,7,6 each 2 cycles, no done, valid continuously 1 until stop; stop at A=6 -> valid=0 next cycle, A=6, done=0.
REQ-031 start and stop high together in IDLE -> state stays IDLE, valid=0, busy=0.
REQ-032 rst pulsed asynchronously (between edges) while A=5 in RUN -> A=0, valid=0, busy=0 immediately, no done pulse.
REQ-033 SCAN_MASK_EN defined, mask=8'b1010_0100, dir=0, single=1, PRESCALE=1 -> A=2,5,7 one cycle each, then done; mask=8'h00 start -> no response.
REQ-034 PRESCALE=1, dir=0 single=1 -> A changes every cycle 0..7, done pulse on 9th cycle after start edge.
